// File: rtl/cnn_run_ctrl.sv
// cnn_run_ctrl: run controller between board I/O and the CNN core.
// Debounces the push button, latches an image index from the switches,
// pulses start to the core, waits for the dense-layer result under a
// watchdog, and shows {run count, class} (or all-ones on timeout) on LEDs.
// Ports:
//   clk, resetn        clock, asynchronous active-low reset
//   sw                 image index select
//   button             raw asynchronous push button (active-high)
//   mode_i             0 = single-shot, 1 = continuous auto-run
//   dense_valid_i      one-cycle pulse, core result ready
//   dense_class_i      class index, valid with dense_valid_i
//   start_o            one-cycle start pulse to the core
//   img_sel_o          latched image index, stable during a run
//   busy_o             high while waiting for the core
//   done_o             high while a result/timeout is displayed
//   timeout_o          sticky: last run timed out
//   led_o              {run_cnt, class} or all-ones on timeout
module cnn_run_ctrl #(
  parameter int SW_W        = 4,
  parameter int LED_W       = 8,
  parameter int CLASS_W     = 4,
  parameter int DEB_CYC     = 16,
  parameter int TIMEOUT_CYC = 65536
) (
  input  logic               clk,
  input  logic               resetn,
  input  logic [SW_W-1:0]    sw,
  input  logic               button,
  input  logic               mode_i,
  input  logic               dense_valid_i,
  input  logic [CLASS_W-1:0] dense_class_i,
  output logic               start_o,
  output logic [SW_W-1:0]    img_sel_o,
  output logic               busy_o,
  output logic               done_o,
  output logic               timeout_o,
  output logic [LED_W-1:0]   led_o
);

  localparam int RUN_W = LED_W - CLASS_W;
  localparam int DEB_W = $clog2(DEB_CYC + 1);
  localparam int TMR_W = $clog2(TIMEOUT_CYC + 1);
  localparam logic [DEB_W-1:0] DEB_LAST = DEB_W'(DEB_CYC - 1);
  localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(TIMEOUT_CYC - 1);

  typedef enum logic [1:0] {S_IDLE, S_START, S_WAIT, S_SHOW} state_t;

  state_t             r_state;
  state_t             w_next;
  logic               r_sync1, r_sync2;
  logic               r_deb, r_deb_d, r_btn_rise;
  logic [DEB_W-1:0]   r_deb_cnt;
  logic [TMR_W-1:0]   r_timer;
  logic [RUN_W-1:0]   r_run_cnt;
  logic [RUN_W-1:0]   w_run_nxt;
  logic [SW_W-1:0]    r_img_sel;
  logic               r_timeout;
  logic [LED_W-1:0]   r_led;
  logic               w_go;
  logic               w_timer_hit;

  // Button path: two-flop synchroniser, then a debouncer that accepts a new
  // level only after DEB_CYC consecutive differing cycles. The rise pulse is
  // registered, which fixes the press-to-start latency at DEB_CYC+4 edges.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_sync1    <= 1'b0;
      r_sync2    <= 1'b0;
      r_deb      <= 1'b0;
      r_deb_d    <= 1'b0;
      r_btn_rise <= 1'b0;
      r_deb_cnt  <= '0;
    end else begin
      r_sync1    <= button;
      r_sync2    <= r_sync1;
      r_deb_d    <= r_deb;
      r_btn_rise <= r_deb & ~r_deb_d;
      if (r_sync2 == r_deb) begin
        r_deb_cnt <= '0;
      end else if (r_deb_cnt == DEB_LAST) begin
        r_deb     <= r_sync2;
        r_deb_cnt <= '0;
      end else begin
        r_deb_cnt <= r_deb_cnt + DEB_W'(1);
      end
    end
  end

  assign w_go        = r_btn_rise | mode_i;
  assign w_timer_hit = (r_timer == TMR_LAST);
  assign w_run_nxt   = r_run_cnt + RUN_W'(1);

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) r_state <= S_IDLE;
    else         r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:  if (w_go) w_next = S_START;
      S_START: w_next = S_WAIT;
      S_WAIT:  if (dense_valid_i || w_timer_hit) w_next = S_SHOW;
      S_SHOW:  if (w_go) w_next = S_START;
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_timer   <= '0;
      r_run_cnt <= '0;
      r_img_sel <= '0;
      r_timeout <= 1'b0;
      r_led     <= '0;
    end else begin
      case (r_state)
        S_IDLE, S_SHOW: begin
          if (w_go) r_img_sel <= sw;
        end
        S_START: begin
          r_timeout <= 1'b0;
          r_timer   <= '0;
        end
        S_WAIT: begin
          if (!w_timer_hit) r_timer <= r_timer + TMR_W'(1);
          // A result arriving on the last watchdog cycle takes priority.
          if (dense_valid_i) begin
            r_run_cnt <= w_run_nxt;
            r_led     <= {w_run_nxt, dense_class_i};
          end else if (w_timer_hit) begin
            r_timeout <= 1'b1;
            r_led     <= '1;
          end
        end
        default: ;
      endcase
    end
  end

  assign start_o   = (r_state == S_START);
  assign busy_o    = (r_state == S_WAIT);
  assign done_o    = (r_state == S_SHOW);
  assign img_sel_o = r_img_sel;
  assign timeout_o = r_timeout;
  assign led_o     = r_led;

endmodule

// File: tb/tb_cnn_run_ctrl.sv
module tb_cnn_run_ctrl;

  logic       clk = 1'b0;
  logic       resetn;
  logic [3:0] sw;
  logic       button;
  logic       mode_i;
  logic       dense_valid_i;
  logic [3:0] dense_class_i;
  logic       start_o;
  logic [3:0] img_sel_o;
  logic       busy_o;
  logic       done_o;
  logic       timeout_o;
  logic [7:0] led_o;

  int checks = 0;
  int errors = 0;
  logic [7:0] exp_q[$];
  int rc = 0;          // model of the run counter

  cnn_run_ctrl #(.SW_W(4), .LED_W(8), .CLASS_W(4), .DEB_CYC(4), .TIMEOUT_CYC(64)) dut (
    .clk(clk), .resetn(resetn), .sw(sw), .button(button), .mode_i(mode_i),
    .dense_valid_i(dense_valid_i), .dense_class_i(dense_class_i),
    .start_o(start_o), .img_sel_o(img_sel_o), .busy_o(busy_o), .done_o(done_o),
    .timeout_o(timeout_o), .led_o(led_o)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Press and hold the button with deb low; start must be seen exactly after
  // edge 7 (i.e. sampled high at edge 8). Returns just after edge 8 (first WAIT cycle).
  task automatic run_press(input string tag, input logic [3:0] s);
    int first = -1;
    int highs = 0;
    sw = s;
    button = 1'b1;
    for (int e = 0; e <= 8; e++) begin
      tick();
      if (start_o === 1'b1) begin
        highs++;
        if (first < 0) first = e;
      end
    end
    button = 1'b0;
    chk({tag, "_start_edge"}, first, 7);
    chk({tag, "_start_len"}, highs, 1);
    chk({tag, "_img_sel"}, img_sel_o, s);
    chk({tag, "_busy"}, busy_o, 1);
  endtask

  task automatic send_valid(input logic [3:0] cls);
    rc = (rc + 1) % 16;
    exp_q.push_back({rc[3:0], cls});
    dense_valid_i = 1'b1;
    dense_class_i = cls;
    tick();
    dense_valid_i = 1'b0;
  endtask

  task automatic check_result(input string tag);
    logic [7:0] e;
    int n = 0;
    while (done_o !== 1'b1 && n < 200) begin
      tick();
      n++;
    end
    chk({tag, "_done"}, done_o, 1);
    if (exp_q.size() == 0) begin
      chk({tag, "_queue_empty"}, exp_q.size(), 1);
    end else begin
      e = exp_q.pop_front();
      chk({tag, "_led"}, led_o, e);
    end
  endtask

  initial begin
    int extra;
    logic wrapped;
    resetn = 1'b0; sw = '0; button = 1'b0; mode_i = 1'b0;
    dense_valid_i = 1'b0; dense_class_i = '0;
    ticks(3);
    chk("rst_start", start_o, 0);
    chk("rst_busy", busy_o, 0);
    chk("rst_done", done_o, 0);
    chk("rst_timeout", timeout_o, 0);
    chk("rst_led", led_o, 8'h00);
    chk("rst_img", img_sel_o, 0);
    resetn = 1'b1;
    ticks(2);

    // Stray valid in IDLE
    dense_valid_i = 1'b1; dense_class_i = 4'hC;
    ticks(3);
    dense_valid_i = 1'b0;
    chk("idle_stray_led", led_o, 8'h00);
    chk("idle_stray_done", done_o, 0);
    ticks(2);

    // 1: first run
    run_press("t1", 4'h5);
    send_valid(4'h3);
    chk("t1_busy_low", busy_o, 0);
    check_result("t1");
    ticks(10);

    // 2: glitch then a real press
    extra = 0;
    button = 1'b1;
    ticks(3);
    button = 1'b0;
    for (int i = 0; i < 15; i++) begin
      tick();
      if (start_o === 1'b1) extra++;
    end
    chk("t2_glitch_nostart", extra, 0);
    run_press("t2", 4'h9);
    send_valid(4'h7);
    check_result("t2");
    ticks(10);

    // 3: timeout
    run_press("t3", 4'h2);
    ticks(63);
    chk("t3_still_busy", busy_o, 1);
    chk("t3_no_timeout_yet", timeout_o, 0);
    exp_q.push_back(8'hFF);
    tick();
    chk("t3_timeout", timeout_o, 1);
    check_result("t3");
    ticks(10);

    // 4: valid on the last watchdog cycle; also checks timeout cleared
    run_press("t4", 4'h6);
    chk("t4_timeout_cleared", timeout_o, 0);
    ticks(63);
    chk("t4_still_busy", busy_o, 1);
    send_valid(4'h5);
    chk("t4_timeout_low", timeout_o, 0);
    check_result("t4");

    // 6: stray valid in SHOW, button press during WAIT
    dense_valid_i = 1'b1; dense_class_i = 4'hA;
    tick();
    dense_valid_i = 1'b0;
    chk("t6_show_stray_led", led_o, 8'h35);
    ticks(10);
    run_press("t6", 4'h3);
    ticks(8);
    extra = 0;
    button = 1'b1;
    for (int i = 0; i < 10; i++) begin
      tick();
      if (start_o === 1'b1) extra++;
    end
    button = 1'b0;
    chk("t6_wait_press_nostart", extra, 0);
    chk("t6_wait_busy", busy_o, 1);
    send_valid(4'h1);
    check_result("t6");
    extra = 0;
    for (int i = 0; i < 12; i++) begin
      tick();
      if (start_o === 1'b1) extra++;
    end
    chk("t6_dropped_press", extra, 0);
    chk("t6_led_hold", led_o, 8'h41);

    // 5: continuous mode, 16 runs with wrap
    wrapped = 1'b0;
    sw = 4'hB;
    mode_i = 1'b1;
    tick();
    for (int r = 0; r < 16; r++) begin
      chk("t5_start", start_o, 1);
      tick();
      ticks(r % 3);
      send_valid(4'(r));
      if (rc == 0) wrapped = 1'b1;
      check_result("t5");
      if (rc == 0) chk("t5_wrap_upper", led_o[7:4], 0);
      tick();
    end
    chk("t5_wrapped", wrapped, 1);
    chk("t5_img_sel", img_sel_o, 4'hB);
    tick();
    ticks(3);
    chk("t5_mid_wait", busy_o, 1);
    resetn = 1'b0;
    mode_i = 1'b0;
    #1;
    chk("t5_rst_busy", busy_o, 0);
    chk("t5_rst_start", start_o, 0);
    chk("t5_rst_done", done_o, 0);
    chk("t5_rst_led", led_o, 8'h00);
    chk("t5_rst_img", img_sel_o, 0);
    chk("t5_rst_timeout", timeout_o, 0);
    ticks(2);
    resetn = 1'b1;
    ticks(2);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: observed running expected finished");
    $fatal(1, "global timeout");
  end

endmodule
